// File: rtl/dmem_responder.sv
// Hart dmem responder: word RAM, cycle counter, console FIFO, error monitor.
// Optional console FIFO/STATUS/handshake built only with DMEM_CONSOLE_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready,
  output logic        o_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [63:0]   cycle;
  logic [31:0]   hi_shadow;
  logic [31:0]   status;
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic          access;
  logic          rd;
  logic          wr;
  logic          ram_hit;
  logic          mmio_hit;
  logic          err_now;

  assign widx     = i_dmem_addr[AW+1:2];
  assign off      = i_dmem_addr[3:2];
  assign access   = i_dmem_ren | i_dmem_wen;
  assign rd       = i_dmem_ren & ~i_dmem_wen;
  assign wr       = i_dmem_wen & ~i_dmem_ren;
  assign ram_hit  = {1'b0, i_dmem_addr} < RAM_BYTES;
  assign mmio_hit = i_dmem_addr[31:4] == MMIO_BASE[31:4];
  assign err_now  = access & ((i_dmem_ren & i_dmem_wen)
                  | (i_dmem_addr[1:0] != 2'b00)
                  | (i_dmem_mask == 4'b0000));

  // RAM is never reset; a write at a reset edge is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b])
          mem[widx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    o_dmem_rdata = '0;
    if (rd) begin
      unique case (1'b1)
        ram_hit: o_dmem_rdata = mem[widx];
        mmio_hit: begin
          case (off)
            2'd1:    o_dmem_rdata = status;
            2'd2:    o_dmem_rdata = cycle[31:0];
            2'd3:    o_dmem_rdata = hi_shadow;
            default: o_dmem_rdata = '0;
          endcase
        end
        default: o_dmem_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle     <= '0;
      hi_shadow <= '0;
      o_err     <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (rd && mmio_hit && off == 2'd2)
        hi_shadow <= cycle[63:32];
      if (err_now)
        o_err <= 1'b1;
    end
  end

`ifdef DMEM_CONSOLE_EN
  logic [7:0] fifo [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;
  logic       drop;
  logic       full;
  logic       push_req;
  logic       push;
  logic       pop;

  assign full     = count == 3'd4;
  assign push_req = wr & mmio_hit & (off == 2'd0) & i_dmem_mask[0];
  assign pop      = o_con_valid & i_con_ready;
  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign push     = push_req & (~full | pop);

  assign o_con_valid = count != 3'd0;
  assign o_con_data  = o_con_valid ? fifo[rptr] : 8'd0;
  assign status      = {27'd0, drop, count, full};

  always_ff @(posedge i_clk) begin
    if (push)
      fifo[wptr] <= i_dmem_wdata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      drop  <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 2'd1;
      if (pop)
        rptr <= rptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
      if (push_req && full && !pop)
        drop <= 1'b1;
    end
  end
`else
  logic unused_ready;

  assign unused_ready = i_con_ready;
  assign o_con_valid  = 1'b0;
  assign o_con_data   = 8'd0;
  assign status       = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus corner sequences.
// Console expectations follow DMEM_CONSOLE_EN as compiled.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dmem_addr  (addr),
    .i_dmem_ren   (ren),
    .i_dmem_wen   (wen),
    .i_dmem_wdata (wdata),
    .i_dmem_mask  (mask),
    .o_dmem_rdata (rdata),
    .o_con_valid  (con_valid),
    .o_con_data   (con_data),
    .i_con_ready  (con_ready),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    ren = r; wen = w; addr = a; wdata = d; mask = m;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    drv(1'b1, 1'b0, a, 32'h0, 4'hF);
    #1 chk(nm, rdata, exp);
    step();
  endtask

  task automatic push(input logic [7:0] b);
    drv(1'b0, 1'b1, MB, {24'h0, b}, 4'h1);
    step();
  endtask

  initial begin
    tv.push_back('{1, 0, 32'h10, 32'h0, 4'hF, 1, 32'hAA22CCDD, "ram_masked"});
    tv.push_back('{0, 1, 32'h14, 32'hDEADBEEF, 4'hF, 0, 32'h0, ""});
    tv.push_back('{1, 0, 32'h14, 32'h0, 4'hF, 1, 32'hDEADBEEF, "ram_full"});
    tv.push_back('{0, 1, 32'h14, 32'h000000AA, 4'h1, 0, 32'h0, ""});
    tv.push_back('{0, 1, 32'h14, 32'h11000000, 4'h8, 0, 32'h0, ""});
    tv.push_back('{1, 0, 32'h14, 32'h0, 4'hF, 1, 32'h11ADBEAA, "ram_lanes"});
    tv.push_back('{0, 1, 32'h20, 32'h12345678, 4'hF, 0, 32'h0, ""});
    tv.push_back('{0, 1, 32'h30, 32'hA5A5A5A5, 4'hF, 0, 32'h0, ""});
    tv.push_back('{0, 1, 32'h0, 32'h01020304, 4'hF, 0, 32'h0, ""});
    tv.push_back('{0, 1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, 32'h0, ""});
    tv.push_back('{1, 0, 32'hFFC, 32'h0, 4'hF, 1, 32'hCAFEF00D, "ram_top"});
    tv.push_back('{0, 1, 32'h1000, 32'h55555555, 4'hF, 0, 32'h0, ""});
    tv.push_back('{1, 0, 32'h1000, 32'h0, 4'hF, 1, 32'h0, "oor_read"});
    tv.push_back('{1, 0, 32'h0, 32'h0, 4'hF, 1, 32'h01020304, "oor_alias"});
    tv.push_back('{0, 0, 32'h10, 32'h0, 4'hF, 1, 32'h0, "ren_low"});
    tv.push_back('{1, 0, MB, 32'h0, 4'hF, 1, 32'h0, "console_rd"});
    tv.push_back('{1, 0, MB + 4, 32'h0, 4'hF, 1, 32'h0, "status_empty"});
    tv.push_back('{1, 0, MB + 16, 32'h0, 4'hF, 1, 32'h0, "mmio_edge"});

    // reset state
    #1;
    drv(1'b1, 1'b0, MB + 8, 32'h0, 4'hF);
    #1;
    chk("rst_valid", {31'd0, con_valid}, 32'd0);
    chk("rst_data", {24'd0, con_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cycle", rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rd_chk("cycle_first", MB + 8, 32'd1);
    rd_chk("cycle_hi0", MB + 12, 32'd0);

    // old data visible alongside a masked write
    drv(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hF);
    step();
    drv(1'b0, 1'b1, 32'h10, 32'h11223344, 4'h4);
    #1 chk("old_data", dut.mem[4], 32'hAABBCCDD);
    step();

    foreach (tv[i]) begin
      drv(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].m);
      #1;
      if (tv[i].chk)
        chk(tv[i].nm, rdata, tv[i].exp);
      step();
    end
    idle();
    #1 chk("no_err", {31'd0, err}, 32'd0);

    // coherent high-word read across a 32-bit carry
    drv(1'b1, 1'b0, MB + 8, 32'h0, 4'hF);
    force dut.cycle = 64'h0000_0001_FFFF_FFFF;
    #1 chk("lo_forced", rdata, 32'hFFFFFFFF);
    release dut.cycle;
    step();
    rd_chk("hi_coherent", MB + 12, 32'h00000001);
    rd_chk("lo_after", MB + 8, 32'h00000001);
    rd_chk("hi_live", MB + 12, 32'h00000002);

`ifdef DMEM_CONSOLE_EN
    con_ready = 1'b0;
    push(8'h41);
    drv(1'b0, 1'b1, MB, 32'h42, 4'h1);
    #1;
    chk("push_valid", {31'd0, con_valid}, 32'd1);
    chk("push_head", {24'd0, con_data}, 32'h41);
    step();
    push(8'h43);
    push(8'h44);
    push(8'h45);
    rd_chk("status_full", MB + 4, 32'h19);
    idle();
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain", {23'd0, con_valid, con_data}, {23'd0, 1'b1, 8'(8'h41 + i)});
      step();
    end
    #1 chk("drain_empty", {31'd0, con_valid}, 32'd0);
    con_ready = 1'b0;
    push(8'h50);
    push(8'h51);
    push(8'h52);
    push(8'h53);
    con_ready = 1'b1;
    push(8'h54);
    con_ready = 1'b0;
    rd_chk("full_pushpop", MB + 4, 32'h19);
    idle();
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain2", {24'd0, con_data}, 32'(8'h51 + i));
      step();
    end
    #1 chk("drain2_empty", {31'd0, con_valid}, 32'd0);
    con_ready = 1'b0;
`else
    push(8'h41);
    idle();
    #1 chk("con_off_valid", {23'd0, con_valid, con_data}, 32'd0);
    rd_chk("con_off_status", MB + 4, 32'd0);
`endif

    // read+write collision
    drv(1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
    #1 chk("rw_rdata", rdata, 32'd0);
    step();
    idle();
    #1 chk("rw_err", {31'd0, err}, 32'd1);
    rd_chk("rw_ram", 32'h20, 32'h12345678);

    // reset mid-stream with queued bytes and an in-flight write
    push(8'h61);
    push(8'h62);
    push(8'h63);
    drv(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, con_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    step();
    rst_n = 1'b1;
    rd_chk("rst_inflight", 32'h30, 32'hA5A5A5A5);
    rd_chk("rst_ram", 32'h10, 32'hAA22CCDD);
    rd_chk("rst_status", MB + 4, 32'd0);

    // misaligned access
    idle();
    #1 chk("clean_err", {31'd0, err}, 32'd0);
    drv(1'b1, 1'b0, 32'h22, 32'h0, 4'hF);
    step();
    idle();
    #1 chk("misalign_err", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 chk("err_cleared", {31'd0, err}, 32'd0);
    step();

    // empty mask
    drv(1'b0, 1'b1, 32'h24, 32'h0, 4'h0);
    step();
    idle();
    #1 chk("mask0_err", {31'd0, err}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
